pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width.
REQ-002 SHALL have ports as listed:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  6  ID-stage instruction [31:26].
- funct  in  6  ID-stage instruction [5:0].
- id_rs  in  RA_W  ID-stage rs field.
- id_rt  in  RA_W  ID-stage rt field.
- ex_br_taken  in  1  EX-stage branch resolved taken, from datapath.
- ex_reg_dst, ex_alu_src, ex_branch, ex_branch_neq, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each  ID/EX control register.
- ex_alu_ctl  out  4  ID/EX ALU control.
- ex_rt  out  RA_W  ID/EX copy of id_rt.
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  EX/MEM control register.
- wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control register.
- stall  out  1  hold PC and IF/ID this cycle.
- if_flush  out  1  zero IF/ID at next edge.
- jump  out  1  ID-stage jump, gated.

Function
REQ-003 SHALL decode combinationally: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, lw 0x23, sw 0x2B; any other opcode SHALL decode to all-zero controls.
REQ-004 SHALL set controls: reg_dst=R; alu_src=lw|sw|addi; reg_write=R|lw|addi; mem_read=mem_to_reg=lw; mem_write=sw; branch=beq; branch_neq=bne.
REQ-005 SHALL set alu_ctl: lw/sw/addi 0010; beq/bne 0110; R by funct 0x20 0010, 0x22 0110, 0x24 0000, 0x25 0001, 0x27 1100, 0x2A 0111, other funct 0010; all else 0000.
REQ-006 SHALL advance controls one stage per cycle: ID->EX->MEM->WB, latency 1 cycle per stage, no holds on EX/MEM or MEM/WB.
REQ-007 SHALL assert load-use stall when ex_mem_read=1, ex_rt!=0, and ex_rt equals a source used by the ID instruction (R/sw/beq/bne: rs and rt; lw/addi: rs only; j: none).
REQ-008 On stall SHALL load a bubble (all ID/EX controls 0, ex_rt 0) into ID/EX; stall=1 for exactly that cycle.
REQ-009 SHALL, when ex_br_taken=1, assert if_flush, load a bubble into ID/EX, force stall=0 and jump=0 (branch squashes the younger ID instruction).
REQ-010 SHALL assert jump and if_flush when ID decodes j and ex_br_taken=0; ID/EX SHALL receive the j controls (all zero).
REQ-011 Priority SHALL be rst > ex_br_taken > load-use stall > normal.
REQ-012 Back-to-back: a stall SHALL not re-assert on the next cycle for the same pair, since the bubble clears ex_mem_read.

Reset
REQ-013 While rst=1 at a clock edge, all ID/EX, EX/MEM, MEM/WB registers SHALL clear to 0; combinational stall, if_flush, jump SHALL be 0 while rst=1.
REQ-014 Reset asserted mid-stall or mid-flush SHALL discard the pending event; first cycle after reset SHALL behave as an empty pipeline.

Configuration
REQ-015 Macro CTRL_IMM_LOGIC_EN: when defined, SHALL also decode andi 0x0C (alu_ctl 0000), ori 0x0D (0001), slti 0x0A (0111), each alu_src=1, reg_write=1, rs-only hazard source; when undefined those opcodes SHALL decode as all-zero controls.

Structure
REQ-016 Shared package ctrl_pkg SHALL hold opcode and funct constants, ALU control codes, and the packed control-bundle typedef.
REQ-017 Hazard logic SHALL be a sub-module hazard_detect (inputs ex_mem_read, ex_rt, id_rs, id_rt, use flags; output load_use).

Verification
REQ-018 lw (0x23) at ID, then three cycles -> ex_mem_read=1, mem_mem_read=1, wb_mem_to_reg=1 on successive cycles; wb_reg_write=1 in cycle 3.
REQ-019 lw writing rt=5 in EX, ID add with rs=5 -> stall=1 one cycle, ID/EX all zero next edge; with rs=rt=0 dependency -> stall=0.
REQ-020 ex_br_taken=1 concurrent with a load-use hazard -> if_flush=1, stall=0, ID/EX bubble.
REQ-021 j (0x02) at ID -> jump=1, if_flush=1; same cycle with ex_br_taken=1 -> jump=0.
REQ-022 R funct 0x27 -> ex_alu_ctl=1100; opcode 0x0D -> ori controls with CTRL_IMM_LOGIC_EN, all zero without.
REQ-023 rst=1 during stall -> next edge all registers 0, stall=0; release -> normal decode resumes.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared decode definitions for the pipeline control unit: opcode and funct
// constants, ALU control codes, the packed control bundle, and the decoders.
// Optional macro CTRL_IMM_LOGIC_EN adds decode of andi / ori / slti.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       branch_neq;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [3:0] alu_ctl;
    } ctrl_t;

    // R-type ALU operation selected by funct; unknown funct falls back to add.
    function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Main decoder; anything not recognised yields an all-zero bundle.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_ctl   = rtype_alu(fn);
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_ctl    = ALU_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_ctl   = ALU_ADD;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_ctl   = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch  = 1'b1;
                c.alu_ctl = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_neq = 1'b1;
                c.alu_ctl    = ALU_SUB;
            end
`ifdef CTRL_IMM_LOGIC_EN
            OP_ANDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_ctl   = ALU_AND;
            end
            OP_ORI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_ctl   = ALU_OR;
            end
            OP_SLTI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_ctl   = ALU_SLT;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Which source registers the ID instruction reads: {use_rs, use_rt}.
    function automatic logic [1:0] src_use(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: return 2'b11;
            OP_LW, OP_ADDI:                  return 2'b10;
`ifdef CTRL_IMM_LOGIC_EN
            OP_ANDI, OP_ORI, OP_SLTI:        return 2'b10;
`endif
            default:                         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Bundle of ID-stage inputs and pipelined control outputs of pipe_ctrl_unit.
// master drives the instruction fields and branch outcome; slave is the unit.
interface pipe_ctrl_unit_if #(parameter int RA_W = 5);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            ex_br_taken;

    logic            ex_reg_dst;
    logic            ex_alu_src;
    logic            ex_branch;
    logic            ex_branch_neq;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_reg_write;
    logic [3:0]      ex_alu_ctl;
    logic [RA_W-1:0] ex_rt;

    logic            mem_mem_read;
    logic            mem_mem_write;
    logic            mem_mem_to_reg;
    logic            mem_reg_write;

    logic            wb_mem_to_reg;
    logic            wb_reg_write;

    logic            stall;
    logic            if_flush;
    logic            jump;

    modport master (
        output opcode, funct, id_rs, id_rt, ex_br_taken,
        input  ex_reg_dst, ex_alu_src, ex_branch, ex_branch_neq, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_ctl, ex_rt,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
               wb_mem_to_reg, wb_reg_write, stall, if_flush, jump
    );

    modport slave (
        input  opcode, funct, id_rs, id_rt, ex_br_taken,
        output ex_reg_dst, ex_alu_src, ex_branch, ex_branch_neq, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_ctl, ex_rt,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
               wb_mem_to_reg, wb_reg_write, stall, if_flush, jump
    );
endinterface

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is a register the
// ID instruction reads forces a one-cycle stall. Register 0 never hazards.
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            use_rs,
    input  logic            use_rt,
    output logic            load_use
);
    // Compare the load destination against each source actually read.
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rt != '0)) begin
            load_use = (use_rs && (ex_rt == id_rs)) || (use_rt && (ex_rt == id_rt));
        end
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decodes the ID instruction, carries its controls
// through ID/EX, EX/MEM and MEM/WB, and raises stall / flush / jump.
// Optional macro CTRL_IMM_LOGIC_EN (see ctrl_pkg) enables andi/ori/slti.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_unit_if.slave bus
);
    ctrl_t           id_ctrl;
    logic [1:0]      id_use;
    logic            id_is_j;
    logic            load_use;
    logic            bubble;

    ctrl_t           ex_ctrl_p0;
    logic [RA_W-1:0] ex_rt_p0;
    logic [3:0]      mem_ctrl_p1;   // {mem_read, mem_write, mem_to_reg, reg_write}
    logic [1:0]      wb_ctrl_p2;    // {mem_to_reg, reg_write}

    assign id_ctrl = decode(bus.opcode, bus.funct);
    assign id_use  = src_use(bus.opcode);
    assign id_is_j = (bus.opcode == OP_J);

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .ex_mem_read (ex_ctrl_p0.mem_read),
        .ex_rt       (ex_rt_p0),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .use_rs      (id_use[1]),
        .use_rt      (id_use[0]),
        .load_use    (load_use)
    );

    // Hazard outputs: taken branch outranks load-use, reset silences all.
    always_comb begin
        bus.stall    = 1'b0;
        bus.if_flush = 1'b0;
        bus.jump     = 1'b0;
        bubble       = 1'b0;
        if (!rst) begin
            if (bus.ex_br_taken) begin
                bus.if_flush = 1'b1;
                bubble       = 1'b1;
            end else begin
                bus.stall    = load_use;
                bubble       = load_use;
                bus.jump     = id_is_j;
                bus.if_flush = id_is_j;
            end
        end
    end

    // ---- ID -> EX / EX -> MEM / MEM -> WB boundaries ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_p0  <= '0;
            ex_rt_p0    <= '0;
            mem_ctrl_p1 <= '0;
            wb_ctrl_p2  <= '0;
        end else begin
            ex_ctrl_p0  <= bubble ? '0 : id_ctrl;
            ex_rt_p0    <= bubble ? '0 : bus.id_rt;
            mem_ctrl_p1 <= {ex_ctrl_p0.mem_read, ex_ctrl_p0.mem_write,
                            ex_ctrl_p0.mem_to_reg, ex_ctrl_p0.reg_write};
            wb_ctrl_p2  <= {mem_ctrl_p1[1], mem_ctrl_p1[0]};
        end
    end

    assign bus.ex_reg_dst     = ex_ctrl_p0.reg_dst;
    assign bus.ex_alu_src     = ex_ctrl_p0.alu_src;
    assign bus.ex_branch      = ex_ctrl_p0.branch;
    assign bus.ex_branch_neq  = ex_ctrl_p0.branch_neq;
    assign bus.ex_mem_read    = ex_ctrl_p0.mem_read;
    assign bus.ex_mem_write   = ex_ctrl_p0.mem_write;
    assign bus.ex_mem_to_reg  = ex_ctrl_p0.mem_to_reg;
    assign bus.ex_reg_write   = ex_ctrl_p0.reg_write;
    assign bus.ex_alu_ctl     = ex_ctrl_p0.alu_ctl;
    assign bus.ex_rt          = ex_rt_p0;

    assign bus.mem_mem_read   = mem_ctrl_p1[3];
    assign bus.mem_mem_write  = mem_ctrl_p1[2];
    assign bus.mem_mem_to_reg = mem_ctrl_p1[1];
    assign bus.mem_reg_write  = mem_ctrl_p1[0];

    assign bus.wb_mem_to_reg  = wb_ctrl_p2[1];
    assign bus.wb_reg_write   = wb_ctrl_p2[0];
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus a random
// run compared against an instruction-level reference model.
module tb_pipe_ctrl_unit;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pipe_ctrl_unit_if #(.RA_W(5)) bus ();

    pipe_ctrl_unit #(.RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pipeline state: bundle {reg_dst, alu_src, branch, branch_neq,
    // mem_read, mem_write, mem_to_reg, reg_write, alu_ctl[3:0]}.
    logic [11:0] mex;
    logic [4:0]  mex_rt;
    logic [3:0]  mmem;
    logic [1:0]  mwb;

    function automatic logic [11:0] mdec(input logic [5:0] op, input logic [5:0] fn);
        logic r, lw, sw, bq, bn, ad, imm;
        logic [3:0] alu;
        r = (op == 6'h00); lw = (op == 6'h23); sw = (op == 6'h2B);
        bq = (op == 6'h04); bn = (op == 6'h05); ad = (op == 6'h08);
        imm = 1'b0; alu = 4'b0000;
`ifdef CTRL_IMM_LOGIC_EN
        if (op == 6'h0C) begin imm = 1'b1; alu = 4'b0000; end
        if (op == 6'h0D) begin imm = 1'b1; alu = 4'b0001; end
        if (op == 6'h0A) begin imm = 1'b1; alu = 4'b0111; end
`endif
        if (lw || sw || ad) alu = 4'b0010;
        if (bq || bn)       alu = 4'b0110;
        if (r) begin
            alu = 4'b0010;
            if (fn == 6'h22) alu = 4'b0110;
            if (fn == 6'h24) alu = 4'b0000;
            if (fn == 6'h25) alu = 4'b0001;
            if (fn == 6'h27) alu = 4'b1100;
            if (fn == 6'h2A) alu = 4'b0111;
        end
        return {r, lw | sw | ad | imm, bq, bn, lw, sw, lw, r | lw | ad | imm, alu};
    endfunction

    function automatic logic mhaz();
        logic rs_used, rt_used;
        logic [5:0] op;
        op = bus.opcode;
        rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        rs_used = rt_used || (op == 6'h23) || (op == 6'h08);
`ifdef CTRL_IMM_LOGIC_EN
        rs_used = rs_used || (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0A);
`endif
        if (!mex[7] || mex_rt == 5'd0) return 1'b0;
        return (rs_used && bus.id_rs == mex_rt) || (rt_used && bus.id_rt == mex_rt);
    endfunction

    function automatic logic [11:0] obs_ex();
        return {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_branch, bus.ex_branch_neq,
                bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_reg_write,
                bus.ex_alu_ctl};
    endfunction

    function automatic logic [3:0] obs_mem();
        return {bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write};
    endfunction

    function automatic logic [1:0] obs_wb();
        return {bus.wb_mem_to_reg, bus.wb_reg_write};
    endfunction

    // One rising edge: the model advances with the inputs present at the edge.
    task automatic edge_step();
        logic h;
        @(posedge clk);
        h = mhaz();
        if (rst) begin
            mex = '0; mex_rt = '0; mmem = '0; mwb = '0;
        end else begin
            mwb  = mmem[1:0];
            mmem = mex[7:4];
            if (bus.ex_br_taken || h) begin
                mex = '0; mex_rt = '0;
            end else begin
                mex = mdec(bus.opcode, bus.funct); mex_rt = bus.id_rt;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic br);
        bus.opcode = op; bus.funct = fn; bus.id_rs = rs; bus.id_rt = rt;
        bus.ex_br_taken = br;
        #1;
    endtask

    task automatic idle();
        set_id(6'h3F, 6'h00, 5'd0, 5'd0, 1'b0);
        edge_step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(6'h02, 6'h00, 5'd1, 5'd1, 1'b1);
        tests++;
        if ({bus.stall, bus.if_flush, bus.jump} !== 3'b000) begin
            fails++; $display("FAIL reset_comb: got %b expected 000", {bus.stall, bus.if_flush, bus.jump});
        end
        edge_step();
        edge_step();
        tests++;
        if ({obs_ex(), bus.ex_rt, obs_mem(), obs_wb()} !== 23'd0) begin
            fails++; $display("FAIL reset_regs: got %h expected 0", {obs_ex(), bus.ex_rt, obs_mem(), obs_wb()});
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_lw_flow();
        set_id(6'h23, 6'h00, 5'd1, 5'd2, 1'b0);
        edge_step();
        set_id(6'h3F, 6'h00, 5'd0, 5'd0, 1'b0);
        tests++;
        if (bus.ex_mem_read !== 1'b1) begin
            fails++; $display("FAIL lw_ex_mem_read: got %b expected 1", bus.ex_mem_read);
        end
        edge_step();
        tests++;
        if (bus.mem_mem_read !== 1'b1) begin
            fails++; $display("FAIL lw_mem_mem_read: got %b expected 1", bus.mem_mem_read);
        end
        edge_step();
        tests++;
        if ({bus.wb_mem_to_reg, bus.wb_reg_write} !== 2'b11) begin
            fails++; $display("FAIL lw_wb: got %b expected 11", {bus.wb_mem_to_reg, bus.wb_reg_write});
        end
        idle();
    endtask

    task automatic test_load_use();
        set_id(6'h23, 6'h00, 5'd0, 5'd5, 1'b0);
        edge_step();
        set_id(6'h00, 6'h20, 5'd5, 5'd1, 1'b0);
        tests++;
        if ({bus.stall, bus.if_flush} !== 2'b10) begin
            fails++; $display("FAIL lu_stall: got %b expected 10", {bus.stall, bus.if_flush});
        end
        edge_step();
        tests++;
        if ({obs_ex(), bus.ex_rt} !== 17'd0) begin
            fails++; $display("FAIL lu_bubble: got %h expected 0", {obs_ex(), bus.ex_rt});
        end
        tests++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL lu_no_restall: got %b expected 0", bus.stall);
        end
        edge_step();
        tests++;
        if ({bus.ex_reg_dst, bus.ex_reg_write, bus.ex_alu_ctl} !== 6'b110010) begin
            fails++; $display("FAIL lu_resume: got %b expected 110010", {bus.ex_reg_dst, bus.ex_reg_write, bus.ex_alu_ctl});
        end
        set_id(6'h23, 6'h00, 5'd0, 5'd0, 1'b0);
        edge_step();
        set_id(6'h00, 6'h20, 5'd0, 5'd0, 1'b0);
        tests++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL lu_zero_reg: got %b expected 0", bus.stall);
        end
        idle();
    endtask

    task automatic test_branch_priority();
        set_id(6'h23, 6'h00, 5'd0, 5'd3, 1'b0);
        edge_step();
        set_id(6'h00, 6'h20, 5'd3, 5'd3, 1'b1);
        tests++;
        if ({bus.if_flush, bus.stall, bus.jump} !== 3'b100) begin
            fails++; $display("FAIL br_prio: got %b expected 100", {bus.if_flush, bus.stall, bus.jump});
        end
        edge_step();
        tests++;
        if ({obs_ex(), bus.ex_rt} !== 17'd0) begin
            fails++; $display("FAIL br_bubble: got %h expected 0", {obs_ex(), bus.ex_rt});
        end
        idle();
    endtask

    task automatic test_jump();
        set_id(6'h02, 6'h00, 5'd0, 5'd0, 1'b0);
        tests++;
        if ({bus.jump, bus.if_flush, bus.stall} !== 3'b110) begin
            fails++; $display("FAIL jump: got %b expected 110", {bus.jump, bus.if_flush, bus.stall});
        end
        set_id(6'h02, 6'h00, 5'd0, 5'd0, 1'b1);
        tests++;
        if ({bus.jump, bus.if_flush} !== 2'b01) begin
            fails++; $display("FAIL jump_squash: got %b expected 01", {bus.jump, bus.if_flush});
        end
        idle();
    endtask

    task automatic test_alu_imm();
        logic [11:0] ori_exp;
        set_id(6'h00, 6'h27, 5'd1, 5'd2, 1'b0);
        edge_step();
        tests++;
        if (bus.ex_alu_ctl !== 4'b1100) begin
            fails++; $display("FAIL nor_alu: got %b expected 1100", bus.ex_alu_ctl);
        end
`ifdef CTRL_IMM_LOGIC_EN
        ori_exp = 12'b0100_0001_0001;
`else
        ori_exp = 12'b0000_0000_0000;
`endif
        set_id(6'h0D, 6'h00, 5'd1, 5'd2, 1'b0);
        edge_step();
        tests++;
        if (obs_ex() !== ori_exp) begin
            fails++; $display("FAIL ori_ctrl: got %b expected %b", obs_ex(), ori_exp);
        end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        set_id(6'h23, 6'h00, 5'd0, 5'd4, 1'b0);
        edge_step();
        set_id(6'h00, 6'h20, 5'd4, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL rst_stall_comb: got %b expected 0", bus.stall);
        end
        edge_step();
        tests++;
        if ({obs_ex(), bus.ex_rt, obs_mem(), obs_wb(), bus.stall} !== 24'd0) begin
            fails++; $display("FAIL rst_mid_stall: got %h expected 0", {obs_ex(), bus.ex_rt, obs_mem(), obs_wb(), bus.stall});
        end
        rst = 1'b0;
        #1;
        edge_step();
        tests++;
        if ({bus.ex_reg_dst, bus.ex_reg_write} !== 2'b11) begin
            fails++; $display("FAIL rst_resume: got %b expected 11", {bus.ex_reg_dst, bus.ex_reg_write});
        end
        idle();
    endtask

    task automatic test_random();
        logic [5:0] ops [11];
        logic [5:0] fns [7];
        logic       h, es, ef, ej;
        ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h11};
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_id(($urandom_range(0, 11) == 11) ? 6'($urandom) : ops[$urandom_range(0, 10)],
                   fns[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
            h  = mhaz();
            es = !rst && !bus.ex_br_taken && h;
            ef = !rst && (bus.ex_br_taken || bus.opcode == 6'h02);
            ej = !rst && !bus.ex_br_taken && bus.opcode == 6'h02;
            tests++;
            if ({bus.stall, bus.if_flush, bus.jump} !== {es, ef, ej}) begin
                fails++; $display("FAIL rnd_comb[%0d]: got %b expected %b", i, {bus.stall, bus.if_flush, bus.jump}, {es, ef, ej});
            end
            tests++;
            if ({obs_ex(), bus.ex_rt} !== {mex, mex_rt}) begin
                fails++; $display("FAIL rnd_ex[%0d]: got %h expected %h", i, {obs_ex(), bus.ex_rt}, {mex, mex_rt});
            end
            tests++;
            if ({obs_mem(), obs_wb()} !== {mmem, mwb}) begin
                fails++; $display("FAIL rnd_mem_wb[%0d]: got %b expected %b", i, {obs_mem(), obs_wb()}, {mmem, mwb});
            end
            edge_step();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        tests = 0; fails = 0;
        mex = '0; mex_rt = '0; mmem = '0; mwb = '0;
        rst = 1'b1;
        bus.opcode = 6'h3F; bus.funct = 6'h00; bus.id_rs = '0; bus.id_rt = '0;
        bus.ex_br_taken = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_lw_flow();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_alu_imm();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
